// File: rtl/program_mem_arbiter_pkg.sv
// Shared types for the program-memory arbiter: arbiter state encoding and pointer sizing.
package program_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_READ    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    // Pointer/grant width; a single consumer still needs one bit.
    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/program_mem_arbiter_picker.sv
// rr_priority_picker: combinational find-first-set over req, starting at ptr and wrapping modulo N.
module rr_priority_picker
    import program_mem_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int W = ptr_bits(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from farthest to nearest so the candidate closest to ptr is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                idx   = W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/program_mem_arbiter.sv
// Arbitrates NUM_CONSUMERS fetcher read channels onto one program-memory read channel.
// Define PROGMEM_ARB_FIXED_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module program_mem_arbiter
    import program_mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data
);

    localparam int PTR_BITS = ptr_bits(NUM_CONSUMERS);

    arb_state_t                       state, state_next;
    logic [PTR_BITS-1:0]              grant, grant_next;
    logic [PTR_BITS-1:0]              search_ptr;
    logic                             pick_found;
    logic [PTR_BITS-1:0]              pick_idx;
    logic [NUM_CONSUMERS-1:0]         ready_next;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] data_next;
    logic                             mem_valid_next;
    logic [ADDR_BITS-1:0]             mem_addr_next;

`ifdef PROGMEM_ARB_FIXED_PRIORITY_EN
    assign search_ptr = '0;
`else
    logic [PTR_BITS-1:0] rr_ptr, rr_ptr_next;
    assign search_ptr = rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) rr_ptr <= '0;
        else       rr_ptr <= rr_ptr_next;
    end
`endif

    rr_priority_picker #(.N(NUM_CONSUMERS)) u_picker (
        .req   (consumer_read_valid),
        .ptr   (search_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ARB_IDLE;
            grant               <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            mem_read_valid      <= 1'b0;
            mem_read_address    <= '0;
        end else begin
            state               <= state_next;
            grant               <= grant_next;
            consumer_read_ready <= ready_next;
            consumer_read_data  <= data_next;
            mem_read_valid      <= mem_valid_next;
            mem_read_address    <= mem_addr_next;
        end
    end

    always_comb begin
        state_next     = state;
        grant_next     = grant;
        ready_next     = consumer_read_ready;
        data_next      = consumer_read_data;
        mem_valid_next = mem_read_valid;
        mem_addr_next  = mem_read_address;
`ifndef PROGMEM_ARB_FIXED_PRIORITY_EN
        rr_ptr_next    = rr_ptr;
`endif
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_next     = pick_idx;
                    mem_addr_next  = consumer_read_address[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
                    mem_valid_next = 1'b1;
                    state_next     = ARB_READ;
                end
            end
            ARB_READ: begin
                // The consumer may have dropped valid; the read still lands in its slot.
                if (mem_read_ready) begin
                    mem_valid_next                                  = 1'b0;
                    data_next[int'(grant)*DATA_BITS +: DATA_BITS]   = mem_read_data;
                    ready_next[grant]                               = 1'b1;
                    state_next                                      = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                if (!consumer_read_valid[grant]) begin
                    ready_next[grant] = 1'b0;
`ifndef PROGMEM_ARB_FIXED_PRIORITY_EN
                    if (grant == PTR_BITS'(NUM_CONSUMERS - 1)) rr_ptr_next = '0;
                    else                                       rr_ptr_next = grant + PTR_BITS'(1);
`endif
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Directed-vector bench for program_mem_arbiter: 4-consumer instance plus a 3-consumer instance for pointer wrap.
module tb_program_mem_arbiter;
    import program_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cvalid = '0;
    logic [31:0] caddr = '0;
    logic [3:0]  cready;
    logic [63:0] cdata;
    logic        mvalid;
    logic [7:0]  maddr;
    logic        mready = 1'b0;
    logic [15:0] mdata = '0;

    logic [2:0]  b_cvalid = '0;
    logic [23:0] b_caddr = '0;
    logic [2:0]  b_cready;
    logic [47:0] b_cdata;
    logic        b_mvalid;
    logic [7:0]  b_maddr;
    logic        b_mready = 1'b0;
    logic [15:0] b_mdata = '0;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    int viol = 0;
    logic mv_prev = 1'b0;

    always #5 clk = ~clk;

    program_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(cvalid), .consumer_read_address(caddr),
        .consumer_read_ready(cready), .consumer_read_data(cdata),
        .mem_read_valid(mvalid), .mem_read_address(maddr),
        .mem_read_ready(mready), .mem_read_data(mdata)
    );

    program_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(3)) dutb (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_cvalid), .consumer_read_address(b_caddr),
        .consumer_read_ready(b_cready), .consumer_read_data(b_cdata),
        .mem_read_valid(b_mvalid), .mem_read_address(b_maddr),
        .mem_read_ready(b_mready), .mem_read_data(b_mdata)
    );

    always @(negedge clk) begin
        if (mvalid && !mv_prev) pulses++;
        mv_prev = mvalid;
        if (!reset && (!$onehot0(cready) || (mvalid && dut.state == ARB_RELEASE))) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits for a grant, checks its address, answers after lat cycles and checks the return.
    task automatic serve(input int idx, input logic [7:0] exp_addr, input logic [15:0] rdata, input int lat);
        int n;
        n = 0;
        while (!mvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_valid", 32'(mvalid), 32'd1);
        chk("grant_addr", 32'(maddr), 32'(exp_addr));
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(mvalid), 32'd1);
            chk("hold_addr", 32'(maddr), 32'(exp_addr));
        end
        mdata  = rdata;
        mready = 1'b1;
        @(negedge clk);
        mready = 1'b0;
        mdata  = 16'hDEAD;
        chk("ready_bits", 32'(cready), 32'(1 << idx));
        chk("data_slot", 32'(cdata[idx*16 +: 16]), 32'(rdata));
        chk("mem_valid_drop", 32'(mvalid), 32'd0);
    endtask

    function automatic logic [15:0] mem_model(input logic [7:0] a);
        return {~a, a};
    endfunction

`ifdef PROGMEM_ARB_FIXED_PRIORITY_EN
    localparam int SECOND_WIN = 0;
`else
    localparam int SECOND_WIN = 3;
`endif

    initial begin
        int p0;
        int n;
        do_reset();
        chk("rst_ready", 32'(cready), 32'd0);
        chk("rst_data_lo", cdata[31:0], 32'd0);
        chk("rst_data_hi", cdata[63:32], 32'd0);
        chk("rst_mvalid", 32'(mvalid), 32'd0);
        chk("rst_maddr", 32'(maddr), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(ARB_IDLE));

        // Single request from consumer 2, memory answers 2 cycles after grant
        caddr[16 +: 8] = 8'h3C;
        cvalid[2] = 1'b1;
        @(negedge clk);
        serve(2, 8'h3C, 16'hA5F0, 2);
        chk("t1_other_slots", 32'(cdata[15:0]), 32'd0);
        cvalid[2] = 1'b0;
        @(negedge clk);
        chk("t1_ready_low", 32'(cready), 32'd0);
        chk("t1_idle", 32'(dut.state), 32'(ARB_IDLE));

        // All four at once from rr_ptr=0
        do_reset();
        caddr = {8'h43, 8'h32, 8'h21, 8'h10};
        p0 = pulses;
        cvalid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            serve(i, 8'(8'h10 + 8'(i) * 8'h11), mem_model(8'(8'h10 + 8'(i) * 8'h11)), 1 + i);
            cvalid[i] = 1'b0;
            @(negedge clk);
        end
        chk("t2_pulses", 32'(pulses - p0), 32'd4);
        chk("t2_slot0", 32'(cdata[15:0]), 32'(mem_model(8'h10)));

        // Fairness: 0 re-requests immediately, 3 continuous
        cvalid = 4'b1001;
        @(negedge clk);
        serve(0, 8'h10, 16'h0F0F, 1);
        cvalid[0] = 1'b0;
        @(negedge clk);
        cvalid[0] = 1'b1;
        serve(SECOND_WIN, (SECOND_WIN == 3) ? 8'h43 : 8'h10, 16'h3C3C, 1);
        cvalid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("t3_idle", 32'(dut.state), 32'(ARB_IDLE));

        // Early drop: consumer 1 releases valid during the read
        cvalid[1] = 1'b1;
        n = 0;
        while (!mvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_grant", 32'(mvalid), 32'd1);
        chk("t4_addr", 32'(maddr), 32'h21);
        @(negedge clk);
        cvalid[1] = 1'b0;
        chk("t4_in_read", 32'(dut.state), 32'(ARB_READ));
        @(negedge clk);
        chk("t4_still_valid", 32'(mvalid), 32'd1);
        mdata  = 16'h1234;
        mready = 1'b1;
        @(negedge clk);
        mready = 1'b0;
        chk("t4_ready", 32'(cready), 32'b0010);
        chk("t4_data", 32'(cdata[31:16]), 32'h1234);
        @(negedge clk);
        chk("t4_ready_gone", 32'(cready), 32'd0);
        chk("t4_idle", 32'(dut.state), 32'(ARB_IDLE));

        // Reset while the read is outstanding
        cvalid[2] = 1'b1;
        n = 0;
        while (!mvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_grant", 32'(mvalid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_mvalid", 32'(mvalid), 32'd0);
        chk("t5_ready", 32'(cready), 32'd0);
        chk("t5_data_lo", cdata[31:0], 32'd0);
        chk("t5_data_hi", cdata[63:32], 32'd0);
        chk("t5_state", 32'(dut.state), 32'(ARB_IDLE));
        reset = 1'b0;
        serve(2, 8'h32, 16'hBEEF, 1);
        cvalid[2] = 1'b0;
        @(negedge clk);

        // Wrap on the 3-consumer instance
        b_caddr[16 +: 8] = 8'h77;
        for (int r = 0; r < 3; r++) begin
            b_cvalid[2] = 1'b1;
            n = 0;
            while (!b_mvalid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t6_grant", 32'(b_mvalid), 32'd1);
            chk("t6_addr", 32'(b_maddr), 32'h77);
            b_mdata  = 16'h5500 + 16'(r);
            b_mready = 1'b1;
            @(negedge clk);
            b_mready = 1'b0;
            chk("t6_ready", 32'(b_cready), 32'b100);
            chk("t6_data", 32'(b_cdata[47:32]), 32'(16'h5500 + 16'(r)));
            b_cvalid[2] = 1'b0;
            @(negedge clk);
            chk("t6_release", 32'(b_cready), 32'd0);
`ifndef PROGMEM_ARB_FIXED_PRIORITY_EN
            chk("t6_rr_wrap", 32'(dutb.rr_ptr), 32'd0);
`endif
        end

        chk("exclusivity", 32'(viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
